// File: rtl/spi_master.sv
// SPI mode-0 master: byte valid/ready in, registered sclk/cs_n/mosi out, full-duplex miso capture.
// cs_n stays low across bytes until a byte marked tx_last has been shifted out.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, HOLD, TRAIL, GAP} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [6:0]    tx_shift, tx_shift_nxt;
    logic [6:0]    rx_shift, rx_shift_nxt;
    logic [7:0]    rx_data_nxt;
    logic          tx_last_q, tx_last_nxt;
    logic          tx_ready_nxt, rx_valid_nxt, sclk_nxt, cs_n_nxt, mosi_nxt;

    logic accept, phase_done, fall, byte_done;

    assign accept     = tx_valid && tx_ready;
    assign phase_done = (hcnt == HMAX);
    assign fall       = (state == SHIFT) && phase_done && sclk;
    assign byte_done  = fall && (bit_cnt == 3'd7);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hcnt      <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            tx_last_q <= 1'b0;
            tx_ready  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            state     <= state_nxt;
            hcnt      <= hcnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx_shift  <= tx_shift_nxt;
            rx_shift  <= rx_shift_nxt;
            tx_last_q <= tx_last_nxt;
            tx_ready  <= tx_ready_nxt;
            rx_valid  <= rx_valid_nxt;
            rx_data   <= rx_data_nxt;
            sclk      <= sclk_nxt;
            cs_n      <= cs_n_nxt;
            mosi      <= mosi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LEAD;
            LEAD:    if (phase_done) state_nxt = SHIFT;
            SHIFT:   if (byte_done) state_nxt = tx_last_q ? TRAIL : HOLD;
            HOLD:    if (accept) state_nxt = LEAD;
            TRAIL:   if (phase_done) state_nxt = GAP;
            GAP:     if (phase_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        hcnt_nxt     = '0;
        bit_cnt_nxt  = bit_cnt;
        tx_shift_nxt = tx_shift;
        rx_shift_nxt = rx_shift;
        rx_data_nxt  = rx_data;
        tx_last_nxt  = tx_last_q;
        rx_valid_nxt = 1'b0;
        sclk_nxt     = sclk;
        mosi_nxt     = mosi;
        // Outputs are registered from the next state, so they line up with the state they describe.
        tx_ready_nxt = (state_nxt == IDLE) || (state_nxt == HOLD);
        cs_n_nxt     = (state_nxt == IDLE) || (state_nxt == GAP);

        if ((state inside {LEAD, SHIFT, TRAIL, GAP}) && !phase_done)
            hcnt_nxt = hcnt + HW'(1);

        if (accept) begin
            tx_shift_nxt = tx_data[6:0];
            tx_last_nxt  = tx_last;
            mosi_nxt     = tx_data[7];
        end

        if ((state == LEAD || state == SHIFT) && phase_done)
            sclk_nxt = !sclk;

        // Falling sclk edge: capture miso and present the next mosi bit in the same cycle.
        if (fall) begin
            rx_shift_nxt = {rx_shift[5:0], miso};
            bit_cnt_nxt  = bit_cnt + 3'd1;
            if (byte_done) begin
                rx_data_nxt  = {rx_shift, miso};
                rx_valid_nxt = 1'b1;
            end else begin
                mosi_nxt     = tx_shift[6];
                tx_shift_nxt = {tx_shift[5:0], 1'b0};
            end
        end

        if (state == GAP && phase_done)
            mosi_nxt = 1'b0;
    end

endmodule
